// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
//   arb_state_t   : FSM state encoding (IDLE, BUSY)
//   MAX_CHANNELS  : upper bound on the requester count
//   onehot()      : binary index -> one-hot vector, MAX_CHANNELS wide
package arbiter_pkg;

  localparam int MAX_CHANNELS  = 8;
  localparam int MAX_SEL_WIDTH = $clog2(MAX_CHANNELS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Callers narrow the result to their own channel count with a size cast.
  function automatic logic [MAX_CHANNELS-1:0] onehot(input logic [MAX_SEL_WIDTH-1:0] index);
    logic [MAX_CHANNELS-1:0] v;
    v        = '0;
    v[index] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker.
// Finds the first set request bit scanning upward from i_ptr, wrapping
// modulo CHANNELS.
//   i_request : request vector
//   i_ptr     : index of the highest-priority channel
//   o_found   : at least one request is set
//   o_winner  : index of the chosen channel (valid when o_found)
module rr_priority_picker
  import arbiter_pkg::*;
#(
  parameter  int CHANNELS  = 8,
  localparam int SEL_WIDTH = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0]  i_request,
  input  logic [SEL_WIDTH-1:0] i_ptr,
  output logic                 o_found,
  output logic [SEL_WIDTH-1:0] o_winner
);

  // The doubled vector only needs 2*CHANNELS-1 bits: the largest index
  // read is (CHANNELS-1) + (CHANNELS-1).
  logic [2*CHANNELS-2:0] w_doubled;
  logic [CHANNELS-1:0]   w_rotated;
  logic [SEL_WIDTH-1:0]  w_offset;

  always_comb begin
    w_doubled = {i_request[CHANNELS-2:0], i_request};
    w_rotated = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_rotated[i] = w_doubled[i + int'(i_ptr)];
    end

    // Lowest set bit of the rotated vector is the offset from i_ptr.
    w_offset = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_rotated[i]) begin
        w_offset = SEL_WIDTH'(i);
      end
    end

    o_found  = |i_request;
    // CHANNELS is a power of two, so the add wraps modulo CHANNELS for free.
    o_winner = i_ptr + w_offset;
  end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter feeding the select input of the 8-to-1 mux.
// A grant is held for a whole burst; the burst closes on a last-beat
// transfer, on the owner dropping its request, or on the beat limit.
//   i_clock    : system clock, rising edge
//   i_reset    : asynchronous active-high reset
//   i_request  : per-channel request level
//   i_last     : final beat of the granted burst
//   i_ready    : downstream accepts the current beat
//   o_valid    : a grant is active
//   o_grant    : one-hot grant, zero when idle
//   o_select   : binary granted index, held while idle
//   o_preempt  : one-cycle pulse after a beat-limit release
//
// state | meaning
// IDLE  | no grant; waiting for any request
// BUSY  | grant held for o_select until the burst ends
module round_robin_arbiter
  import arbiter_pkg::*;
#(
  parameter  int CHANNELS  = 8,
  parameter  int MAX_BEATS = 16,
  localparam int SEL_WIDTH = $clog2(CHANNELS)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [CHANNELS-1:0]  i_request,
  input  logic                 i_last,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [CHANNELS-1:0]  o_grant,
  output logic [SEL_WIDTH-1:0] o_select,
  output logic                 o_preempt
);

  localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BEATS);

  arb_state_t           r_state;
  logic                 r_valid;
  logic [CHANNELS-1:0]  r_grant;
  logic [SEL_WIDTH-1:0] r_select;
  logic                 r_preempt;
  logic [SEL_WIDTH-1:0] r_ptr;
  logic [CNT_W-1:0]     r_count;

  arb_state_t           w_next_state;
  logic                 w_next_valid;
  logic [CHANNELS-1:0]  w_next_grant;
  logic [SEL_WIDTH-1:0] w_next_select;
  logic                 w_next_preempt;
  logic [SEL_WIDTH-1:0] w_next_ptr;
  logic [CNT_W-1:0]     w_next_count;

  logic                 w_xfer;
  logic                 w_last_end;
  logic                 w_abandon;
  logic                 w_limit_end;
  logic                 w_end;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [SEL_WIDTH-1:0] w_select_inc;
  logic [SEL_WIDTH-1:0] w_pick_ptr;
  logic                 w_found;
  logic [SEL_WIDTH-1:0] w_winner;
  logic [CHANNELS-1:0]  w_winner_grant;

  always_comb begin
    w_xfer       = r_valid & i_ready;
    w_cnt_inc    = r_count + CNT_W'(1);
    w_select_inc = r_select + SEL_WIDTH'(1);
    w_last_end   = w_xfer & i_last;
    w_abandon    = ~i_request[r_select];
    w_limit_end  = (MAX_BEATS != 0) && w_xfer && (w_cnt_inc == LIMIT);
    w_end        = (r_state == BUSY) && (w_last_end || w_abandon || w_limit_end);
    // While busy the picker is only consulted at grant end, where the
    // just-finished channel becomes lowest priority.
    w_pick_ptr   = (r_state == BUSY) ? w_select_inc : r_ptr;
  end

  rr_priority_picker #(
    .CHANNELS (CHANNELS)
  ) u_picker (
    .i_request (i_request),
    .i_ptr     (w_pick_ptr),
    .o_found   (w_found),
    .o_winner  (w_winner)
  );

  assign w_winner_grant = CHANNELS'(onehot(MAX_SEL_WIDTH'(w_winner)));

  always_comb begin
    w_next_state   = r_state;
    w_next_valid   = r_valid;
    w_next_grant   = r_grant;
    w_next_select  = r_select;
    w_next_preempt = 1'b0;
    w_next_ptr     = r_ptr;
    w_next_count   = r_count;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_next_state  = BUSY;
          w_next_valid  = 1'b1;
          w_next_grant  = w_winner_grant;
          w_next_select = w_winner;
          w_next_count  = '0;
        end
      end

      BUSY: begin
        if (w_end) begin
          w_next_ptr     = w_select_inc;
          w_next_count   = '0;
          // Pulse only when the beat limit alone closed the burst.
          w_next_preempt = w_limit_end & ~w_last_end & ~w_abandon;
          if (w_found) begin
            w_next_grant  = w_winner_grant;
            w_next_select = w_winner;
          end else begin
            w_next_state = IDLE;
            w_next_valid = 1'b0;
            w_next_grant = '0;
          end
        end else if (w_xfer) begin
          w_next_count = w_cnt_inc;
        end
      end

      default: begin
        w_next_state = IDLE;
        w_next_valid = 1'b0;
        w_next_grant = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_grant   <= '0;
      r_select  <= '0;
      r_preempt <= 1'b0;
      r_ptr     <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_valid   <= w_next_valid;
      r_grant   <= w_next_grant;
      r_select  <= w_next_select;
      r_preempt <= w_next_preempt;
      r_ptr     <= w_next_ptr;
      r_count   <= w_next_count;
    end
  end

  assign o_valid   = r_valid;
  assign o_grant   = r_grant;
  assign o_select  = r_select;
  assign o_preempt = r_preempt;

endmodule

// File: tb/tb_round_robin_arbiter.sv
module tb_round_robin_arbiter;

  localparam int CH = 8;

  logic         clk;
  logic         rst;
  logic [CH-1:0] req;
  logic         last;
  logic         ready;
  logic         valid;
  logic [CH-1:0] grant;
  logic [2:0]   sel;
  logic         pre;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] req;
    logic       last;
    logic       ready;
    logic       e_valid;
    logic [7:0] e_grant;
    logic [2:0] e_sel;
    logic       e_pre;
  } vec_t;

  vec_t vecs[19];

  round_robin_arbiter #(
    .CHANNELS  (CH),
    .MAX_BEATS (4)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_request (req),
    .i_last    (last),
    .i_ready   (ready),
    .o_valid   (valid),
    .o_grant   (grant),
    .o_select  (sel),
    .o_preempt (pre)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic ev, input logic [7:0] eg,
                       input logic [2:0] es, input logic ep);
    checks++;
    if (valid !== ev || grant !== eg || sel !== es || pre !== ep) begin
      errors++;
      $display("FAIL %s: got valid=%b grant=%h sel=%0d pre=%b, want valid=%b grant=%h sel=%0d pre=%b",
               name, valid, grant, sel, pre, ev, eg, es, ep);
    end
  endtask

  // Drive on the falling edge, observe 1 time unit after the rising edge.
  task automatic step(input logic [7:0] r, input logic l, input logic rd);
    @(negedge clk);
    req   = r;
    last  = l;
    ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            req    last  rdy   v     grant  sel   pre
    vecs[0]  = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0, 1'b0};
    vecs[1]  = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[2]  = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[3]  = '{8'h89, 1'b1, 1'b1, 1'b1, 8'h08, 3'd3, 1'b0};
    vecs[4]  = '{8'h89, 1'b1, 1'b1, 1'b1, 8'h80, 3'd7, 1'b0};
    vecs[5]  = '{8'h89, 1'b1, 1'b1, 1'b1, 8'h01, 3'd0, 1'b0};
    vecs[6]  = '{8'h89, 1'b1, 1'b1, 1'b1, 8'h08, 3'd3, 1'b0};
    vecs[7]  = '{8'h89, 1'b1, 1'b1, 1'b1, 8'h80, 3'd7, 1'b0};
    vecs[8]  = '{8'h89, 1'b1, 1'b0, 1'b1, 8'h80, 3'd7, 1'b0};
    vecs[9]  = '{8'h09, 1'b1, 1'b0, 1'b1, 8'h01, 3'd0, 1'b0};
    vecs[10] = '{8'h09, 1'b0, 1'b1, 1'b1, 8'h01, 3'd0, 1'b0};
    vecs[11] = '{8'h09, 1'b1, 1'b1, 1'b1, 8'h08, 3'd3, 1'b0};
    vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0};
    vecs[13] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0};
    vecs[14] = '{8'h10, 1'b0, 1'b0, 1'b1, 8'h10, 3'd4, 1'b0};
    vecs[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd4, 1'b0};
    vecs[16] = '{8'h30, 1'b0, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0};
    vecs[17] = '{8'h30, 1'b1, 1'b1, 1'b1, 8'h10, 3'd4, 1'b0};
    vecs[18] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 1'b0};

    rst   = 1'b1;
    req   = '0;
    last  = 1'b0;
    ready = 1'b0;
    #1;
    check("reset", 1'b0, 8'h00, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].req, vecs[i].last, vecs[i].ready);
      check($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_grant,
            vecs[i].e_sel, vecs[i].e_pre);
    end

    // Channel 2 stalled; channel 5 arrives mid-burst and must wait.
    step(8'h04, 1'b0, 1'b0);
    check("stall_grant2", 1'b1, 8'h04, 3'd2, 1'b0);
    step(8'h04, 1'b0, 1'b0);
    check("stall_hold", 1'b1, 8'h04, 3'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(8'h24, 1'b0, 1'b0);
      check($sformatf("stall_ch5_wait%0d", i), 1'b1, 8'h04, 3'd2, 1'b0);
    end
    step(8'h24, 1'b1, 1'b1);
    check("stall_handover5", 1'b1, 8'h20, 3'd5, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("stall_idle", 1'b0, 8'h00, 3'd5, 1'b0);

    // Beat-limit preemption of channel 1 in favour of channel 6.
    step(8'h02, 1'b0, 1'b0);
    check("pre_grant1", 1'b1, 8'h02, 3'd1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(8'h42, 1'b0, 1'b1);
      check($sformatf("pre_beat%0d", i), 1'b1, 8'h02, 3'd1, 1'b0);
    end
    step(8'h42, 1'b0, 1'b1);
    check("pre_pulse", 1'b1, 8'h40, 3'd6, 1'b1);
    step(8'h42, 1'b1, 1'b1);
    check("pre_regrant1", 1'b1, 8'h02, 3'd1, 1'b0);

    // Last beat coincides with the limit: normal end, no pulse, no bubble.
    for (int i = 1; i <= 3; i++) begin
      step(8'h02, 1'b0, 1'b1);
      check($sformatf("coinc_beat%0d", i), 1'b1, 8'h02, 3'd1, 1'b0);
    end
    step(8'h02, 1'b1, 1'b1);
    check("coinc_end", 1'b1, 8'h02, 3'd1, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("coinc_idle", 1'b0, 8'h00, 3'd1, 1'b0);

    // Move the pointer away from 0, then reset mid-burst.
    step(8'h40, 1'b0, 1'b0);
    check("rst_grant6", 1'b1, 8'h40, 3'd6, 1'b0);
    step(8'h80, 1'b0, 1'b0);
    check("rst_grant7", 1'b1, 8'h80, 3'd7, 1'b0);
    step(8'h80, 1'b0, 1'b1);
    check("rst_beat", 1'b1, 8'h80, 3'd7, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 1'b0, 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_held", 1'b0, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst   = 1'b0;
    req   = 8'h81;
    last  = 1'b0;
    ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ptr0", 1'b1, 8'h01, 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter.md
Name: round_robin_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 8-to-1 multiplexer.
- Chooses one of CHANNELS requesters and drives the mux select input plus a one-hot grant vector.
- Holds each grant for a whole multi-beat burst, which is closed by i_last, by the requester dropping its request, or by a beat-limit preemption.
- Used wherever several masters (fetch, load/store, debug) share one downstream port through the mux.

Parameters:
- CHANNELS, 8, number of requesters; must be a power of two, 2..8.
- SEL_WIDTH, $clog2(CHANNELS), width of o_select; derived, not overridden.
- MAX_BEATS, 16, beats allowed per grant before forced release; 0 disables preemption.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_request  input  CHANNELS  per-channel request; level, held until served.
- i_last  input  1  the granted source marks the final beat of its burst.
- i_ready  input  1  downstream accepts the current beat.
- o_valid  output  1  a grant is active and the beat is presented.
- o_grant  output  CHANNELS  one-hot grant; all zero when idle.
- o_select  output  SEL_WIDTH  binary index of the granted channel; drives the mux select.
- o_preempt  output  1  one-cycle pulse when a grant is force-released by MAX_BEATS.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, o_valid=0, o_grant=0, o_select=0, o_preempt=0.
  - Priority pointer ptr=0, so channel 0 has highest priority. Beat counter=0.
- All outputs are registered. No combinational path from any input to any output.
- Winner selection: the first channel with i_request set, scanning from ptr upward and wrapping modulo CHANNELS.
- IDLE:
  - If |i_request, capture the winner at the next edge: state=BUSY, o_valid=1, o_grant=onehot(winner), o_select=winner, counter=0.
  - Latency from request to grant is 1 cycle.
- BUSY:
  - A beat transfers on any cycle with o_valid && i_ready; each transfer increments the counter.
  - o_select, o_grant and o_valid stay stable until the grant ends.
- The grant ends at the clock edge where any of the following is true:
  - (a) a transfer occurs with i_last=1;
  - (b) i_request[o_select]=0, whether or not a transfer occurs (abandon);
  - (c) MAX_BEATS!=0 and the transfer just made brings the counter to MAX_BEATS.
- On grant end:
  - ptr is set to (o_select+1) mod CHANNELS.
  - The winner is re-evaluated using the new ptr over the current i_request, including the ending channel, which is now lowest priority.
  - If a winner exists, the next grant is loaded on the same edge: zero-bubble handover, o_valid stays 1.
  - Otherwise state=IDLE, o_valid=0, o_grant=0, and o_select holds its last value so the mux output stays stable.
- o_preempt=1 for exactly one cycle after an end caused only by (c). If (a) and (c) coincide, the end counts as normal and o_preempt=0.
- Simultaneous events: (a) together with (b) is a normal end. Requests arriving while BUSY never change the current grant.
- A single requester re-requesting after its end is re-granted with no bubble.
- Reset asserted mid-burst returns everything to the reset values immediately; no beat is reported.
- ptr and counter are not observable at the ports.

Decomposition:
- Package arbiter_pkg:
  - state enum {IDLE, BUSY};
  - function onehot(index) -> CHANNELS bits;
  - constant MAX_CHANNELS=8.
- Sub-module rr_priority_picker, purely combinational:
  - inputs: request vector, ptr;
  - outputs: found flag, winner index;
  - implemented as a doubled-vector rotate followed by a priority encoder.
- The top level contains the FSM, the ptr register, the beat counter and the output registers.

Test Plan:
- Reset, then i_request=8'b0000_0001, i_ready=1, i_last=1 on the first beat → o_valid rises 1 cycle after the request; o_select=0, o_grant=8'h01; the grant ends after 1 beat, ptr=1.
- Requests 8'b1000_1001 held continuously, every beat carries i_last → grant order 0, 3, 7, 0, 3, …; o_valid stays 1 with no idle cycle between grants.
- Channel 2 is granted, i_ready=0 for 5 cycles → o_select=2 held; the grant does not change when channel 5 starts requesting; channel 5 is granted on the edge after the i_last transfer.
- MAX_BEATS=4, channel 1 streams without i_last, channel 6 is requesting → after the 4th transfer o_preempt pulses once and o_select=6; channel 1 is re-granted after channel 6 finishes.
- Channel 4 drops its request mid-burst with no transfer → the grant ends that edge, o_valid=0 if no other requests, o_select stays 4, and the next grant starts from ptr=5.
- i_reset asserted during a BUSY grant while i_ready is high → outputs become 0 asynchronously, without waiting for a clock edge; the next grant again uses channel 0 priority.
